// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The frame layout is: sync byte, 16-bit length in words (LSB first), data words, XOR checksum byte.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CKSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into instruction memory and holds the CPU in reset
// until the image checksum passes; errors leave the CPU held until the next sync byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              res,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_res_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int          TW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t          state, state_nxt;
  logic [15:0]     len;
  logic [ADDR_W:0] word_cnt;
  logic [1:0]      byte_cnt;
  logic [7:0]      cksum;
  logic [31:0]     wdata;
  logic [TW-1:0]   tcnt;
  logic            hold_r, done_r, err_r;

  logic            accept, timeout, len_bad, more_words;
  logic [15:0]     len_new;
  logic [ADDR_W:0] word_inc;

  // A byte arriving in the expiry cycle suppresses the timeout.
  assign accept     = rx_valid && rx_ready;
  assign timeout    = (state != IDLE) && !accept && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign len_new    = {rx_data, len[7:0]};
  assign len_bad    = (len_new == 16'd0) || (32'(len_new) > DEPTH);
  assign word_inc   = word_cnt + 1'b1;
  assign more_words = 32'(word_inc) < 32'(len);

  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && rx_data == SYNC_BYTE) state_nxt = LEN0;
      LEN0:    if (accept) state_nxt = LEN1;
      LEN1:    if (accept) state_nxt = len_bad ? IDLE : DATA;
      DATA:    if (accept && byte_cnt == 2'd3) state_nxt = WRITE;
      WRITE:   state_nxt = more_words ? DATA : CKSUM;
      CKSUM:   if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_comb begin
    rx_ready = (state != WRITE);
    busy     = (state != IDLE);
    imem_we  = (state == WRITE);
  end

  assign imem_addr    = word_cnt[ADDR_W-1:0];
  assign imem_wdata   = wdata;
  assign cpu_res_hold = hold_r;
  assign done         = done_r;
  assign err          = err_r;

  // Datapath: length capture, word assembly, running checksum and status flags.
  always_ff @(posedge clk) begin
    if (res) begin
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      cksum    <= '0;
      wdata    <= '0;
      tcnt     <= '0;
      hold_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE || accept) tcnt <= '0;
      else                         tcnt <= tcnt + 1'b1;
      if (timeout) err_r <= 1'b1;
      case (state)
        IDLE: if (accept && rx_data == SYNC_BYTE) begin
          hold_r   <= 1'b1;
          err_r    <= 1'b0;
          cksum    <= '0;
          word_cnt <= '0;
          byte_cnt <= '0;
        end
        LEN0: if (accept) len[7:0] <= rx_data;
        LEN1: if (accept) begin
          len[15:8] <= rx_data;
          if (len_bad) err_r <= 1'b1;
        end
        DATA: if (accept) begin
          wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
          cksum    <= cksum ^ rx_data;
          byte_cnt <= byte_cnt + 1'b1;
        end
        WRITE: word_cnt <= word_inc;
        CKSUM: if (accept) begin
          if (rx_data == cksum) begin
            done_r <= 1'b1;
            hold_r <= 1'b0;
          end else begin
            err_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
